// File: rtl/apb_wdt_if.sv
// APB2 responder bus for the watchdog: select/enable/address/write from the bridge, read data back.
interface apb_wdt_if;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata
    );
endinterface

// File: rtl/apb_wdt.sv
// APB watchdog: counts down from LOAD, raises an interrupt on the first timeout and a sticky
// reset request on the second unless software clears the interrupt in between.
module apb_wdt (
    input  logic     pclk,
    input  logic     presetn,
    apb_wdt_if.slave apb,
    output logic     wdt_int,
    output logic     wdt_rst_req
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFS_W  = 3;

    localparam logic [DATA_W-1:0] ALL_ONES   = '1;
    localparam logic [DATA_W-1:0] UNLOCK_KEY = 32'h1ACC_E551;

    localparam logic [OFS_W-1:0] OFS_LOAD   = 3'd0;
    localparam logic [OFS_W-1:0] OFS_VALUE  = 3'd1;
    localparam logic [OFS_W-1:0] OFS_CTRL   = 3'd2;
    localparam logic [OFS_W-1:0] OFS_INTCLR = 3'd3;
    localparam logic [OFS_W-1:0] OFS_RIS    = 3'd4;
    localparam logic [OFS_W-1:0] OFS_LOCK   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_EXPIRED,
        ST_RESET_REQ
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DATA_W-1:0]   r_load;
    logic [DATA_W-1:0]   w_load_nxt;
    logic [DATA_W-1:0]   r_value;
    logic [DATA_W-1:0]   w_value_nxt;
    logic                r_en;
    logic                w_en_nxt;
    logic                r_rsten;
    logic                w_rsten_nxt;
    logic                r_ris;
    logic                w_ris_nxt;
    logic                r_rst_req;
    logic                w_rst_req_nxt;
    logic                r_locked;
    logic                w_locked_nxt;

    logic                w_wr;
    logic                w_rd;
    logic [OFS_W-1:0]    w_ofs;
    logic                w_wr_load;
    logic                w_wr_ctrl;
    logic                w_wr_intclr;
    logic                w_wr_lock;
    logic                w_timeout;
    logic                w_unused;

    // Address decode; LOCK stays writable so software can always unlock.
    assign w_wr        = apb.psel & apb.penable & apb.pwrite;
    assign w_rd        = apb.psel & ~apb.pwrite;
    assign w_ofs       = apb.paddr[4:2];
    assign w_wr_load   = w_wr & ~r_locked & (w_ofs == OFS_LOAD);
    assign w_wr_ctrl   = w_wr & ~r_locked & (w_ofs == OFS_CTRL);
    assign w_wr_intclr = w_wr & ~r_locked & (w_ofs == OFS_INTCLR);
    assign w_wr_lock   = w_wr & (w_ofs == OFS_LOCK);
    assign w_timeout   = (r_value == '0);
    assign w_unused    = ^{apb.paddr[15:5], apb.paddr[1:0]};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_load    <= ALL_ONES;
            r_value   <= ALL_ONES;
            r_en      <= 1'b0;
            r_rsten   <= 1'b0;
            r_ris     <= 1'b0;
            r_rst_req <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_load    <= w_load_nxt;
            r_value   <= w_value_nxt;
            r_en      <= w_en_nxt;
            r_rsten   <= w_rsten_nxt;
            r_ris     <= w_ris_nxt;
            r_rst_req <= w_rst_req_nxt;
            r_locked  <= w_locked_nxt;
        end
    end

    // Priority while counting: disable, then interrupt clear, then timeout, then LOAD write.
    always_comb begin
        w_state_nxt   = r_state;
        w_value_nxt   = r_value;
        w_ris_nxt     = r_ris;
        w_rst_req_nxt = r_rst_req;
        w_load_nxt    = w_wr_load ? apb.pwdata : r_load;
        w_en_nxt      = w_wr_ctrl ? apb.pwdata[0] : r_en;
        w_rsten_nxt   = w_wr_ctrl ? apb.pwdata[1] : r_rsten;
        w_locked_nxt  = w_wr_lock ? (apb.pwdata != UNLOCK_KEY) : r_locked;

        case (r_state)
            ST_IDLE: begin
                if (w_wr_intclr) begin
                    w_ris_nxt   = 1'b0;
                    w_value_nxt = r_load;
                end else if (w_wr_ctrl && apb.pwdata[0]) begin
                    w_value_nxt = r_load;
                    w_state_nxt = r_ris ? ST_EXPIRED : ST_COUNT;
                end
            end
            ST_COUNT, ST_EXPIRED: begin
                if (w_wr_ctrl && !apb.pwdata[0]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wr_intclr) begin
                    w_ris_nxt   = 1'b0;
                    w_value_nxt = r_load;
                    w_state_nxt = ST_COUNT;
                end else if (w_timeout) begin
                    if (r_state == ST_COUNT) begin
                        w_ris_nxt   = 1'b1;
                        w_value_nxt = w_load_nxt;
                        w_state_nxt = ST_EXPIRED;
                    end else if (r_rsten) begin
                        w_rst_req_nxt = 1'b1;
                        w_state_nxt   = ST_RESET_REQ;
                    end else begin
                        w_value_nxt = w_load_nxt;
                    end
                end else if (w_wr_load) begin
                    w_value_nxt = apb.pwdata;
                end else begin
                    w_value_nxt = r_value - DATA_W'(1);
                end
            end
            ST_RESET_REQ: begin
                w_state_nxt = ST_RESET_REQ;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Combinational read mux; write-only and reserved offsets return zero.
    always_comb begin
        apb.prdata = '0;
        if (w_rd) begin
            case (w_ofs)
                OFS_LOAD:   apb.prdata = r_load;
                OFS_VALUE:  apb.prdata = r_value;
                OFS_CTRL:   apb.prdata = {30'd0, r_rsten, r_en};
                OFS_RIS:    apb.prdata = {31'd0, r_ris};
                OFS_LOCK:   apb.prdata = {31'd0, r_locked};
                default:    apb.prdata = '0;
            endcase
        end
    end

    assign wdt_int     = r_ris;
    assign wdt_rst_req = r_rst_req;

endmodule

// File: tb/tb_apb_wdt.sv
// Bench for apb_wdt: directed register-level scenarios plus random APB traffic, all checked
// against a flag-based behavioural model of the watchdog rules.
module tb_apb_wdt;

    localparam logic [31:0] KEY = 32'h1ACC_E551;

    logic pclk;
    logic presetn;
    logic wdt_int;
    logic wdt_rst_req;

    apb_wdt_if u_if ();

    apb_wdt u_dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .apb         (u_if),
        .wdt_int     (wdt_int),
        .wdt_rst_req (wdt_rst_req)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int unsigned n_cmp;
    int unsigned n_err;

    // Reference model state
    logic [31:0] m_load;
    logic [31:0] m_value;
    bit          m_en;
    bit          m_rsten;
    bit          m_ris;
    bit          m_locked;
    bit          m_rst_req;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_load    = 32'hFFFF_FFFF;
        m_value   = 32'hFFFF_FFFF;
        m_en      = 1'b0;
        m_rsten   = 1'b0;
        m_ris     = 1'b0;
        m_locked  = 1'b0;
        m_rst_req = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] ofs);
        case (ofs)
            3'd0:    return m_load;
            3'd1:    return m_value;
            3'd2:    return {30'd0, m_rsten, m_en};
            3'd4:    return {31'd0, m_ris};
            3'd5:    return {31'd0, m_locked};
            default: return 32'd0;
        endcase
    endfunction

    // One rising edge of the watchdog rules, using the bus inputs present at that edge.
    function automatic void model_step();
        bit          wr;
        bit          wl, wc, wi, wk;
        logic [2:0]  ofs;
        logic [31:0] d;
        logic [31:0] new_load;
        wr  = u_if.psel && u_if.penable && u_if.pwrite;
        ofs = u_if.paddr[4:2];
        d   = u_if.pwdata;
        wl  = wr && !m_locked && ofs == 3'd0;
        wc  = wr && !m_locked && ofs == 3'd2;
        wi  = wr && !m_locked && ofs == 3'd3;
        wk  = wr && ofs == 3'd5;
        new_load = wl ? d : m_load;

        if (m_rst_req) begin
            // terminal: counter frozen, interrupt clear has no effect
        end else if (!m_en) begin
            if (wi) begin
                m_ris   = 1'b0;
                m_value = m_load;
            end
            if (wc && d[0]) m_value = m_load;
        end else begin
            if (wc && !d[0]) begin
                // disabled: value holds
            end else if (wi) begin
                m_ris   = 1'b0;
                m_value = m_load;
            end else if (m_value == 0) begin
                if (!m_ris) begin
                    m_ris   = 1'b1;
                    m_value = new_load;
                end else if (m_rsten) begin
                    m_rst_req = 1'b1;
                end else begin
                    m_value = new_load;
                end
            end else if (wl) begin
                m_value = d;
            end else begin
                m_value = m_value - 32'd1;
            end
        end

        m_load = new_load;
        if (wc) begin
            m_en    = d[0];
            m_rsten = d[1];
        end
        if (wk) m_locked = (d != KEY);
    endfunction

    // Advance one edge and compare the registered outputs.
    task automatic tick();
        @(posedge pclk);
        if (presetn) model_step();
        #1;
        check_eq("wdt_int", 32'(wdt_int), 32'(m_ris));
        check_eq("wdt_rst_req", 32'(wdt_rst_req), 32'(m_rst_req));
    endtask

    task automatic apb_cycle(input logic s, input logic e, input logic w,
                             input logic [15:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        logic [31:0] exp;
        u_if.psel    = s;
        u_if.penable = e;
        u_if.pwrite  = w;
        u_if.paddr   = a;
        u_if.pwdata  = d;
        #1;
        exp = (s && !w) ? model_read(a[4:2]) : 32'd0;
        rd  = u_if.prdata;
        check_eq("prdata", rd, exp);
        tick();
    endtask

    function automatic logic [15:0] mk_addr(input logic [2:0] ofs);
        logic [15:0] a;
        a      = 16'($urandom);
        a[4:2] = ofs;
        return a;
    endfunction

    task automatic idle(input int n);
        logic [31:0] rd;
        for (int i = 0; i < n; i++) apb_cycle(1'b0, 1'b0, 1'b0, 16'($urandom), 32'($urandom), rd);
    endtask

    task automatic apb_write(input logic [2:0] ofs, input logic [31:0] d);
        logic [15:0] a;
        logic [31:0] rd;
        a = mk_addr(ofs);
        apb_cycle(1'b1, 1'b0, 1'b1, a, d, rd);
        apb_cycle(1'b1, 1'b1, 1'b1, a, d, rd);
    endtask

    // Returns the setup-phase sample of prdata.
    task automatic apb_read(input logic [2:0] ofs, output logic [31:0] rd);
        logic [15:0] a;
        logic [31:0] rd2;
        a = mk_addr(ofs);
        apb_cycle(1'b1, 1'b0, 1'b0, a, 32'd0, rd);
        apb_cycle(1'b1, 1'b1, 1'b0, a, 32'd0, rd2);
    endtask

    task automatic do_reset();
        u_if.psel    = 1'b0;
        u_if.penable = 1'b0;
        u_if.pwrite  = 1'b0;
        presetn      = 1'b0;
        #1;
        model_reset();
        check_eq("rst_int", 32'(wdt_int), 32'd0);
        check_eq("rst_req", 32'(wdt_rst_req), 32'd0);
        tick();
        presetn = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        n_cmp = 0;
        n_err = 0;
        u_if.psel    = 1'b0;
        u_if.penable = 1'b0;
        u_if.pwrite  = 1'b0;
        u_if.paddr   = '0;
        u_if.pwdata  = '0;
        presetn      = 1'b0;
        model_reset();
        #12;
        presetn = 1'b1;
        check_eq("init_int", 32'(wdt_int), 32'd0);
        check_eq("init_req", 32'(wdt_rst_req), 32'd0);
        check_eq("init_prdata", u_if.prdata, 32'd0);

        // Reset values
        apb_read(3'd0, rd); check_eq("reset_load", rd, 32'hFFFF_FFFF);
        apb_read(3'd1, rd); check_eq("reset_value", rd, 32'hFFFF_FFFF);
        apb_read(3'd2, rd); check_eq("reset_ctrl", rd, 32'd0);
        apb_read(3'd4, rd); check_eq("reset_ris", rd, 32'd0);
        apb_read(3'd5, rd); check_eq("reset_lock", rd, 32'd0);

        // LOAD=5, enable, watch the countdown cycle by cycle
        apb_write(3'd0, 32'd5);
        apb_write(3'd2, 32'd1);
        for (int k = 0; k < 6; k++) begin
            apb_cycle(1'b1, k[0], 1'b0, mk_addr(3'd1), 32'd0, rd);
            check_eq("countdown", rd, 32'(5 - k));
        end
        check_eq("first_timeout_int", 32'(wdt_int), 32'd1);
        apb_read(3'd1, rd); check_eq("reload_value", rd, 32'd5);
        apb_write(3'd2, 32'd0);
        apb_write(3'd3, 32'd0);

        // Second timeout with RSTEN, never cleared
        apb_write(3'd0, 32'd3);
        apb_write(3'd2, 32'd3);
        idle(10);
        check_eq("second_timeout_req", 32'(wdt_rst_req), 32'd1);
        apb_write(3'd3, 32'd0);
        check_eq("req_sticky", 32'(wdt_rst_req), 32'd1);
        apb_read(3'd4, rd); check_eq("ris_after_late_clear", rd, 32'd1);
        do_reset();
        check_eq("req_cleared", 32'(wdt_rst_req), 32'd0);

        // INTCLR landing on the edge of the second timeout
        apb_write(3'd0, 32'd3);
        apb_write(3'd2, 32'd3);
        idle(6);
        apb_write(3'd3, 32'hDEAD_BEEF);
        check_eq("clear_wins_req", 32'(wdt_rst_req), 32'd0);
        apb_read(3'd1, rd); check_eq("clear_wins_value", rd, 32'd3);
        apb_read(3'd4, rd); check_eq("clear_wins_ris", rd, 32'd0);
        do_reset();

        // Lock blocks CTRL; unlock allows disable
        apb_write(3'd0, 32'd40);
        apb_write(3'd2, 32'd1);
        apb_write(3'd5, 32'd0);
        apb_write(3'd2, 32'd0);
        apb_read(3'd2, rd); check_eq("locked_ctrl", rd, 32'd1);
        apb_read(3'd5, rd); check_eq("lock_reads_1", rd, 32'd1);
        apb_write(3'd5, KEY);
        apb_write(3'd2, 32'd0);
        apb_read(3'd5, rd); check_eq("unlock_reads_0", rd, 32'd0);
        apb_read(3'd1, rd);
        apb_read(3'd1, rd);
        do_reset();

        // LOAD=0: interrupt one edge after enable, reset request the edge after
        apb_write(3'd0, 32'd0);
        apb_write(3'd2, 32'd3);
        check_eq("load0_int_pre", 32'(wdt_int), 32'd0);
        tick();
        check_eq("load0_int", 32'(wdt_int), 32'd1);
        check_eq("load0_req_pre", 32'(wdt_rst_req), 32'd0);
        tick();
        check_eq("load0_req", 32'(wdt_rst_req), 32'd1);
        do_reset();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int unsigned op;
            op = $urandom_range(0, 99);
            if (op < 3) begin
                do_reset();
            end else if (op < 30) begin
                idle(int'($urandom_range(1, 4)));
            end else if (op < 55) begin
                apb_read(3'($urandom_range(0, 7)), rd);
            end else begin
                logic [2:0]  ofs;
                logic [31:0] d;
                ofs = 3'($urandom_range(0, 5));
                case (ofs)
                    3'd0:    d = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 60)) : 32'($urandom_range(0, 8));
                    3'd2:    d = 32'($urandom_range(0, 3));
                    3'd5:    d = ($urandom_range(0, 9) < 8) ? KEY : 32'($urandom);
                    default: d = 32'($urandom);
                endcase
                apb_write(ofs, d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
